// File: rtl/prbs_pkg.sv
// Shared constants, types and step helpers for the PRBS generator/checker.
// Polynomials are Fibonacci form: out = s[n-1], feedback = s[n-1] ^ s[t-1].
package prbs_pkg;

    localparam int unsigned STATE_W = 31;
    localparam int unsigned POLY_W  = 2;
    localparam int unsigned LEN_W   = 6;

    localparam logic [STATE_W-1:0] SEED = STATE_W'(1);

    typedef enum logic [POLY_W-1:0] {
        POLY_7  = 2'd0,
        POLY_15 = 2'd1,
        POLY_23 = 2'd2,
        POLY_31 = 2'd3
    } poly_e;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    function automatic logic [LEN_W-1:0] poly_len(input logic [POLY_W-1:0] sel);
        case (sel)
            POLY_7:  return LEN_W'(7);
            POLY_15: return LEN_W'(15);
            POLY_23: return LEN_W'(23);
            default: return LEN_W'(31);
        endcase
    endfunction

    // Mask selecting the n most recent history bits.
    function automatic logic [STATE_W-1:0] poly_mask(input logic [POLY_W-1:0] sel);
        case (sel)
            POLY_7:  return STATE_W'(31'h0000_007F);
            POLY_15: return STATE_W'(31'h0000_7FFF);
            POLY_23: return STATE_W'(31'h007F_FFFF);
            default: return '1;
        endcase
    endfunction

    // One serial step: returns {output bit, next state}.
    function automatic logic [STATE_W:0] prbs_step(input logic [STATE_W-1:0] s,
                                                   input logic [POLY_W-1:0]  sel);
        logic msb;
        logic tap;
        case (sel)
            POLY_7:  begin msb = s[6];  tap = s[5];  end
            POLY_15: begin msb = s[14]; tap = s[13]; end
            POLY_23: begin msb = s[22]; tap = s[17]; end
            default: begin msb = s[30]; tap = s[27]; end
        endcase
        return {msb, s[STATE_W-2:0], msb ^ tap};
    endfunction

    // Recurrence check of bit b against history h (h[0] is the previous bit).
    function automatic logic prbs_mism(input logic [STATE_W-1:0] h,
                                       input logic               b,
                                       input logic [POLY_W-1:0]  sel);
        case (sel)
            POLY_7:  return b ^ h[6]  ^ h[5];
            POLY_15: return b ^ h[14] ^ h[13];
            POLY_23: return b ^ h[22] ^ h[17];
            default: return b ^ h[30] ^ h[27];
        endcase
    endfunction

endpackage

// File: rtl/prbs_gen_chk_chk.sv
// Self-synchronising PRBS checker: history, per-word mismatch count,
// FILL/HUNT/LOCKED acquisition FSM and saturating error counter.
module prbs_gen_chk_chk
    import prbs_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOCK_WORDS   = 4,
    parameter int unsigned UNLOCK_WORDS = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [POLY_W-1:0] poly,
    input  logic              restart,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned MISM_W  = $clog2(DATA_W + 1);
    localparam int unsigned RUN_MAX = (LOCK_WORDS > UNLOCK_WORDS) ? LOCK_WORDS : UNLOCK_WORDS;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
    localparam int unsigned FILL_W  = 7;

    chk_state_e         state_q, state_d;
    logic [STATE_W-1:0] hist_q, hist_d, hist_w;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [RUN_W-1:0]   run_q, run_d, bad_q, bad_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_q;
    logic [MISM_W-1:0]  mism;
    logic               clean;
    logic [CNT_W:0]     sum;

    // Walk the word oldest-bit-first through the history.
    always_comb begin
        hist_w = hist_q;
        mism   = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            mism   = mism + MISM_W'(prbs_mism(hist_w, data[i], poly));
            hist_w = {hist_w[STATE_W-2:0], data[i]};
        end
        clean = (mism == '0) && ((hist_w & poly_mask(poly)) != '0);
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        run_d   = run_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, cnt_q} + (CNT_W + 1)'(mism);
        if (restart) begin
            state_d = ST_FILL;
            hist_d  = '0;
            fill_d  = '0;
            run_d   = '0;
            bad_d   = '0;
        end else if (valid) begin
            hist_d = hist_w;
            case (state_q)
                ST_FILL: begin
                    fill_d = fill_q + FILL_W'(DATA_W);
                    if (fill_d >= FILL_W'(poly_len(poly))) state_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (clean) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_d == RUN_W'(LOCK_WORDS)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                            bad_d   = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                    if (mism != '0) begin
                        bad_d = bad_q + RUN_W'(1);
                        if (bad_d == RUN_W'(UNLOCK_WORDS)) begin
                            state_d = ST_HUNT;
                            bad_d   = '0;
                            run_d   = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
        if (clr_cnt) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FILL;
            hist_q   <= '0;
            fill_q   <= '0;
            run_q    <= '0;
            bad_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign locked  = locked_q;
    assign err_cnt = cnt_q;

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 word generator with single-bit error injection,
// paired with a self-synchronising checker on the receive side.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOCK_WORDS   = 4,
    parameter int unsigned UNLOCK_WORDS = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        poly_sel,
    input  logic              gen_en,
    input  logic              inj_err,
    output logic [DATA_W-1:0] gen_data,
    output logic              gen_valid,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              chk_valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [POLY_W-1:0]  poly_q;
    logic               poly_chg;
    logic [STATE_W-1:0] gen_state_q, gen_state_d;
    logic [STATE_W:0]   step;
    logic [DATA_W-1:0]  word_d, gen_data_q;
    logic               gen_valid_q;
    logic               inj_pend_q;

    assign poly_chg = (poly_sel != poly_q);

    // DATA_W serial steps per word, first bit out lands in the MSB.
    always_comb begin
        gen_state_d = gen_state_q;
        step        = '0;
        word_d      = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            step        = prbs_step(gen_state_d, poly_q);
            word_d[i]   = step[STATE_W];
            gen_state_d = step[STATE_W-1:0];
        end
        word_d[DATA_W-1] = word_d[DATA_W-1] ^ (inj_err | inj_pend_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_q      <= '0;
            gen_state_q <= SEED;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            inj_pend_q  <= 1'b0;
        end else begin
            poly_q      <= poly_sel;
            gen_valid_q <= 1'b0;
            if (poly_chg) begin
                gen_state_q <= SEED;
            end else if (gen_en) begin
                gen_state_q <= gen_state_d;
                gen_data_q  <= word_d;
                gen_valid_q <= 1'b1;
            end
            if (gen_en && !poly_chg) inj_pend_q <= 1'b0;
            else if (inj_err)        inj_pend_q <= 1'b1;
        end
    end

    assign gen_data  = gen_data_q;
    assign gen_valid = gen_valid_q;

    prbs_gen_chk_chk #(
        .DATA_W       (DATA_W),
        .LOCK_WORDS   (LOCK_WORDS),
        .UNLOCK_WORDS (UNLOCK_WORDS),
        .CNT_W        (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .poly    (poly_q),
        .restart (poly_chg),
        .data    (chk_data),
        .valid   (chk_valid),
        .clr_cnt (clr_cnt),
        .locked  (locked),
        .err_cnt (err_cnt)
    );

endmodule
